// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
//
// Holds the PC, which drives the instruction-memory address directly. The
// fetched instruction is latched into IF/ID for the decode stage. Stalls,
// downstream redirects and the two-step EXEC sequence are handled here.
// EXEC first fetches one target instruction, then resumes at the saved
// return address.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stall              hold PC, IF/ID and FSM
//   redirect_valid/pc  taken branch / JAL / JR target (highest priority)
//   exe_req/target/return
//                      EXEC decoded in ID: target to run and address to resume at
//   imem_addr          instruction-memory address (= PC register)
//   imem_rdata         asynchronous instruction-memory read data
//   if_id_*            IF/ID register: valid, instr, fetch address + 1, exe_pre
module if_stage #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               exe_req,
  input  logic [ADDR_W-1:0]  exe_target,
  input  logic [ADDR_W-1:0]  exe_return,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus1,
  output logic               if_id_exe_pre
);

  typedef enum logic {StNormal, StExeFetch} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  saved_pc_q, saved_pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_plus1_q, pc_plus1_d;
  logic               exe_pre_q, exe_pre_d;
  logic [ADDR_W-1:0]  pc_inc;

  // Wraps modulo 2^ADDR_W.
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    exe_pre_d  = exe_pre_q;

    if (redirect_valid) begin
      // Redirect wins even over stall and cancels any in-progress EXEC.
      pc_d      = redirect_pc;
      state_d   = StNormal;
      valid_d   = 1'b0;
      instr_d   = '0;
      exe_pre_d = 1'b0;
    end else if (exe_req && !stall) begin
      // Discard the wrong-path instruction fetched behind the EXEC.
      pc_d       = exe_target;
      saved_pc_d = exe_return;
      state_d    = StExeFetch;
      valid_d    = 1'b0;
      instr_d    = '0;
      exe_pre_d  = 1'b0;
    end else if (!stall) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata;
      pc_plus1_d = pc_inc;
      unique case (state_q)
        StNormal: begin
          exe_pre_d = 1'b0;
          pc_d      = pc_inc;
        end
        StExeFetch: begin
          exe_pre_d = 1'b1;
          pc_d      = saved_pc_q;
          state_d   = StNormal;
        end
        default: begin
          exe_pre_d = 1'b0;
          pc_d      = pc_inc;
          state_d   = StNormal;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StNormal;
      pc_q       <= ADDR_W'(RESET_PC);
      saved_pc_q <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus1_q <= '0;
      exe_pre_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      exe_pre_q  <= exe_pre_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus1 = pc_plus1_q;
  assign if_id_exe_pre  = exe_pre_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Instruction memory returns 16'h1000 + addr.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        exe_req;
  logic [15:0] exe_target;
  logic [15:0] exe_return;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_exe_pre;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 16'h1000 + imem_addr;

  if_stage #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .RESET_PC(0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .exe_req       (exe_req),
    .exe_target    (exe_target),
    .exe_return    (exe_return),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_exe_pre (if_id_exe_pre)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [15:0] instr,
                            input logic [15:0] pp1, input logic pre, input logic [15:0] addr);
    check_eq({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    check_eq({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
    check_eq({tag, ".pc_plus1"}, 32'(if_id_pc_plus1), 32'(pp1));
    check_eq({tag, ".exe_pre"}, 32'(if_id_exe_pre), 32'(pre));
    check_eq({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr));
  endtask

  task automatic check_flushed(input string tag, input logic [15:0] addr);
    check_eq({tag, ".valid"}, 32'(if_id_valid), 32'd0);
    check_eq({tag, ".exe_pre"}, 32'(if_id_exe_pre), 32'd0);
    check_eq({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr));
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    exe_req = 1'b0;
    exe_target = '0;
    exe_return = '0;
    step();
    step();
    check_ifid("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    rst = 1'b0;

    // Free-running fetch.
    for (int i = 0; i < 4; i++) begin
      step();
      check_ifid("run", 1'b1, 16'(16'h1000 + i), 16'(i + 1), 1'b0, 16'(i + 1));
    end
    step();
    check_ifid("run4", 1'b1, 16'h1004, 16'h0005, 1'b0, 16'h0005);

    // Stall three cycles at pc=5.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 1'b1, 16'h1004, 16'h0005, 1'b0, 16'h0005);
    end
    // exe_req during stall is ignored.
    exe_req = 1'b1;
    exe_target = 16'h0300;
    exe_return = 16'h0301;
    step();
    check_ifid("stall_exe", 1'b1, 16'h1004, 16'h0005, 1'b0, 16'h0005);
    exe_req = 1'b0;
    stall = 1'b0;
    step();
    check_ifid("release", 1'b1, 16'h1005, 16'h0006, 1'b0, 16'h0006);

    // Redirect wins over stall.
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    stall = 1'b1;
    step();
    check_ifid("redir", 1'b0, 16'h0000, 16'h0006, 1'b0, 16'h0040);
    redirect_valid = 1'b0;
    stall = 1'b0;
    step();
    check_ifid("redir+1", 1'b1, 16'h1040, 16'h0041, 1'b0, 16'h0041);

    // EXEC sequence.
    exe_req = 1'b1;
    exe_target = 16'h0080;
    exe_return = 16'h0011;
    step();
    check_flushed("exec+1", 16'h0080);
    exe_req = 1'b0;
    step();
    check_ifid("exec+2", 1'b1, 16'h1080, 16'h0081, 1'b1, 16'h0011);
    step();
    check_ifid("exec+3", 1'b1, 16'h1011, 16'h0012, 1'b0, 16'h0012);

    // EXEC stalled in EXE_FETCH, then cancelled by redirect.
    exe_req = 1'b1;
    step();
    check_flushed("xs+1", 16'h0080);
    exe_req = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_flushed("xs_stall", 16'h0080);
    end
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0020;
    step();
    check_flushed("xs_redir", 16'h0020);
    redirect_valid = 1'b0;
    step();
    check_ifid("xs_after", 1'b1, 16'h1020, 16'h0021, 1'b0, 16'h0021);

    // PC wrap.
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    check_flushed("wrap_redir", 16'hFFFF);
    redirect_valid = 1'b0;
    step();
    check_ifid("wrap", 1'b1, 16'h0FFF, 16'h0000, 1'b0, 16'h0000);

    // Reset while in EXE_FETCH.
    exe_req = 1'b1;
    exe_target = 16'h0080;
    exe_return = 16'h0011;
    step();
    check_flushed("rx_exec", 16'h0080);
    exe_req = 1'b0;
    rst = 1'b1;
    step();
    check_ifid("rx_reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    rst = 1'b0;
    step();
    check_ifid("rx_after", 1'b1, 16'h1000, 16'h0001, 1'b0, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage, 16-bit-instruction CPU.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction into IF/ID, which feeds the decode-stage control unit (opcode = instr[15:12]) and its EXE_pre input.
- Applies stalls, control-flow redirects and the two-step EXEC sequence: fetch one target instruction, then resume at the saved return address.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 16, instruction width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: hold PC, IF/ID and FSM
redirect_valid  in  1  taken branch / JAL / JR resolved downstream
redirect_pc  in  ADDR_W  redirect target
exe_req  in  1  EXEC decoded in ID (control-unit EXE_cur)
exe_target  in  ADDR_W  address of the instruction EXEC runs
exe_return  in  ADDR_W  address after the EXEC instruction
imem_addr  out  ADDR_W  instruction-memory address, equals PC (combinational)
imem_rdata  in  INSTR_W  instruction at imem_addr, same cycle (asynchronous read)
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  INSTR_W  latched instruction
if_id_pc_plus1  out  ADDR_W  fetch address + 1 of latched instruction
if_id_exe_pre  out  1  latched instruction is an EXEC target; drives control-unit EXE_pre

Behaviour:
- State: pc, saved_pc, FSM {NORMAL, EXE_FETCH}, IF/ID register (valid, instr, pc_plus1, exe_pre).
- Reset (rst=1 at edge; overrides everything, including mid-EXEC):
  - pc=RESET_PC, saved_pc=0, state=NORMAL.
  - if_id_valid=0, if_id_instr=0, if_id_pc_plus1=0, if_id_exe_pre=0.
- Per-edge priority when rst=0: redirect_valid > (exe_req && !stall) > stall > normal advance.
- redirect_valid=1 (any state, even with stall=1):
  - pc<=redirect_pc, state<=NORMAL (an in-progress EXEC is cancelled).
  - IF/ID flushed: valid=0, instr=0, exe_pre=0.
- exe_req=1, stall=0, no redirect:
  - pc<=exe_target, saved_pc<=exe_return, state<=EXE_FETCH.
  - IF/ID flushed; the wrong-path instruction fetched after EXEC is discarded.
- exe_req while stall=1: ignored. Decode re-presents it once the stall is released.
- stall=1, no redirect: pc, saved_pc, state and all IF/ID fields hold. imem_addr stays stable.
- NORMAL advance:
  - IF/ID <= {1, imem_rdata, pc+1, 0}.
  - pc<=pc+1.
- EXE_FETCH advance:
  - IF/ID <= {1, imem_rdata, pc+1, 1}.
  - pc<=saved_pc, state<=NORMAL.
  - Exactly one instruction carries exe_pre=1.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000 with no flag.
- Latency: one cycle from fetch address to the IF/ID output. One flush bubble per redirect. Two IF/ID slots per EXEC (bubble, then target).
- exe_req arriving in EXE_FETCH is illegal (the target is never decoded as EXEC while it has exe_pre set). The stated priority still applies.
- No combinational path from any input to any IF/ID output. imem_addr depends only on the pc register.

Test Plan:
- Reset then 4 free-running cycles, imem returns 16'h1000+addr:
  - IF/ID shows instr 16'h1000..16'h1003 with pc_plus1 1..4, valid=1, exe_pre=0.
  - imem_addr steps 0,1,2,3,4.
- Stall held 3 cycles at pc=5:
  - imem_addr stays 5 and all IF/ID outputs are frozen.
  - On release, IF/ID gets the addr-5 instruction and pc goes to 6.
- redirect_valid with redirect_pc=16'h0040 asserted together with stall=1:
  - Next cycle pc=16'h0040 and if_id_valid=0.
  - The following cycle IF/ID holds the addr-0x40 instruction.
- exe_req with exe_target=16'h0080, exe_return=16'h0011:
  - Cycle+1: IF/ID flushed, pc=0x80.
  - Cycle+2: IF/ID has the addr-0x80 instruction with exe_pre=1, pc=0x11.
  - Cycle+3: addr-0x11 instruction with exe_pre=0.
- EXEC with stall=1 in the EXE_FETCH cycle, then redirect to 0x20 on release:
  - pc stays 0x80 while stalled.
  - On the redirect, state returns to NORMAL, pc=0x20 and no exe_pre=1 instruction is ever latched.
- pc=16'hFFFF advance: if_id_pc_plus1=0 and next imem_addr=0. Assert rst while in EXE_FETCH: all outputs return to their reset values and pc=RESET_PC.
